// File: rtl/ic_bd_pkg.sv
// Shared definitions for the binDCT block sequencer: FSM state encoding,
// block geometry and a small row helper.
package ic_bd_pkg;

  // One 8x8 block spans eight line-buffer rows
  localparam int BLOCK_ROWS = 8;
  localparam int ROW_W      = 3;

  // Sequencer states; encodings are fixed so they can be probed externally
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_STRIP = 3'd1,
    READ       = 3'd2,
    RELEASE    = 3'd3,
    DONE       = 3'd4
  } seq_state_t;

  // True on the final row of a block
  function automatic logic is_last_row(input logic [ROW_W-1:0] row);
    return row == ROW_W'(BLOCK_ROWS - 1);
  endfunction

endpackage

// File: rtl/ic_bd_block_addr_gen.sv
// Row / block-column address generator for the block sequencer.
// Produces the line-buffer word address {blk_col, row} and flags the first
// row of a block and the final read of a strip.
module ic_bd_block_addr_gen
  import ic_bd_pkg::*;
#(
  parameter int BLK_W  = 8,
  parameter int ADDR_W = BLK_W + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [BLK_W-1:0]  last_col,
  output logic [ADDR_W-1:0] addr,
  output logic              row0,
  output logic              strip_end
);

  logic [ROW_W-1:0] row;
  logic [BLK_W-1:0] blk_col;
  logic             row_last;

  assign row_last  = is_last_row(row);
  assign strip_end = row_last && (blk_col == last_col);
  assign row0      = (row == '0);
  assign addr      = {blk_col, row};

  // Step one row per issued read; wrap into the next block column, and back
  // to column 0 after the last row of the last block in the strip
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row     <= '0;
      blk_col <= '0;
    end else if (clear) begin
      row     <= '0;
      blk_col <= '0;
    end else if (advance) begin
      if (row_last) begin
        row     <= '0;
        blk_col <= strip_end ? '0 : blk_col + 1'b1;
      end else begin
        row <= row + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ic_bd_block_sequencer.sv
// Front-end scheduler of the 2D binDCT processor. Walks a frame in 8x8 block
// order out of a ping-pong strip buffer, feeds valid rows to BD1, releases
// each strip once consumed and honours the downstream stall.
// Optional macro IC_BD_SEQ_STALLCNT_EN adds a saturating stall_count output.
module ic_bd_block_sequencer
  import ic_bd_pkg::*;
#(
  parameter int BLK_W  = 8,
  parameter int ADDR_W = BLK_W + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BLK_W-1:0]  cfg_width_blk,
  input  logic [BLK_W-1:0]  cfg_height_blk,
  input  logic              LB_strip_ready,
  input  logic              ds_stall,
  output logic              LB_readrequest,
  output logic [ADDR_W-1:0] LB_read_addr,
  output logic              LB_strip_release,
  output logic              BD1_inputready,
  output logic              block_start,
  output logic              frame_done,
  output logic              busy
`ifdef IC_BD_SEQ_STALLCNT_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [BLK_W-1:0] cfg_w;
  logic [BLK_W-1:0] cfg_h;
  logic [BLK_W-1:0] strip;
  logic             start_acc;
  logic             row0;
  logic             strip_end;
  logic             last_strip;

  assign start_acc      = start && (state == IDLE);
  assign last_strip     = (strip == cfg_h);
  assign LB_readrequest = (state == READ) && !ds_stall;

  ic_bd_block_addr_gen #(
    .BLK_W  (BLK_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start_acc),
    .advance   (LB_readrequest),
    .last_col  (cfg_w),
    .addr      (LB_read_addr),
    .row0      (row0),
    .strip_end (strip_end)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; a stalled final row keeps the FSM in READ until issued
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start)          next_state = WAIT_STRIP;
      WAIT_STRIP: if (LB_strip_ready) next_state = READ;
      READ:       if (LB_readrequest && strip_end) next_state = RELEASE;
      RELEASE:    next_state = last_strip ? DONE : WAIT_STRIP;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Frame geometry is captured once per accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_w <= '0;
      cfg_h <= '0;
    end else if (start_acc) begin
      cfg_w <= cfg_width_blk;
      cfg_h <= cfg_height_blk;
    end
  end

  // Strip counter advances on each non-final release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               strip <= '0;
    else if (start_acc)                         strip <= '0;
    else if ((state == RELEASE) && !last_strip) strip <= strip + 1'b1;
  end

  // Registered status outputs; pulses line up with the state they describe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BD1_inputready   <= 1'b0;
      block_start      <= 1'b0;
      LB_strip_release <= 1'b0;
      frame_done       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      BD1_inputready   <= LB_readrequest;
      block_start      <= LB_readrequest && row0;
      LB_strip_release <= (next_state == RELEASE);
      frame_done       <= (next_state == DONE);
      busy             <= (next_state != IDLE);
    end
  end

`ifdef IC_BD_SEQ_STALLCNT_EN
  // Saturating count of stalled READ cycles, kept after the frame ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        stall_count <= '0;
    else if (start_acc)  stall_count <= '0;
    else if ((state == READ) && ds_stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ic_bd_block_sequencer.sv
// Self-checking bench for ic_bd_block_sequencer: a cycle table for the
// single-block frame, a frame-level address model for longer runs, and
// hand-written stall, strip-gap, start-while-busy and reset sequences.
module tb_ic_bd_block_sequencer;

  localparam int BLK_W  = 8;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [BLK_W-1:0]  cfg_width_blk;
  logic [BLK_W-1:0]  cfg_height_blk;
  logic              LB_strip_ready;
  logic              ds_stall;
  logic              LB_readrequest;
  logic [ADDR_W-1:0] LB_read_addr;
  logic              LB_strip_release;
  logic              BD1_inputready;
  logic              block_start;
  logic              frame_done;
  logic              busy;
`ifdef IC_BD_SEQ_STALLCNT_EN
  logic [15:0]       stall_count;
`endif

  ic_bd_block_sequencer #(.BLK_W(BLK_W), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .cfg_width_blk    (cfg_width_blk),
    .cfg_height_blk   (cfg_height_blk),
    .LB_strip_ready   (LB_strip_ready),
    .ds_stall         (ds_stall),
    .LB_readrequest   (LB_readrequest),
    .LB_read_addr     (LB_read_addr),
    .LB_strip_release (LB_strip_release),
    .BD1_inputready   (BD1_inputready),
    .block_start      (block_start),
    .frame_done       (frame_done),
    .busy             (busy)
`ifdef IC_BD_SEQ_STALLCNT_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model: every expected read address in issue order
  logic [ADDR_W-1:0] exp_q[$];
  bit mon_en = 1'b0;
  int n_reads, n_bd1, n_bs, n_rel, n_done;
  bit prev_rr = 1'b0;
  bit prev_row0 = 1'b0;

  typedef struct {
    bit                ready;
    bit                stall;
    bit                rr;
    logic [ADDR_W-1:0] addr;
    bit                bd1;
    bit                bs;
    bit                rel;
    bit                done;
    bit                bsy;
  } vec_t;

  vec_t tbl[12];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rdy, input bit stl);
    LB_strip_ready = rdy;
    ds_stall       = stl;
  endtask

  function automatic vec_t mk(input bit rr, input int addr, input bit bd1,
                              input bit bs, input bit rel, input bit done,
                              input bit bsy);
    vec_t v;
    v.ready = 1'b1; v.stall = 1'b0;
    v.rr = rr; v.addr = ADDR_W'(addr); v.bd1 = bd1; v.bs = bs;
    v.rel = rel; v.done = done; v.bsy = bsy;
    return v;
  endfunction

  task automatic buildModel(input int w, input int h);
    exp_q.delete();
    for (int s = 0; s <= h; s++)
      for (int c = 0; c <= w; c++)
        for (int r = 0; r < 8; r++)
          exp_q.push_back({BLK_W'(c), 3'(r)});
  endtask

  // Per-cycle protocol monitor against the model
  always @(negedge clk) begin
    if (mon_en) begin
      if (LB_readrequest) begin
        n_reads++;
        if (exp_q.size() == 0) checkOutput("extra_read", 32'd1, 32'd0);
        else checkOutput("read_addr", 32'(LB_read_addr), 32'(exp_q.pop_front()));
      end
      if (ds_stall) checkOutput("read_while_stalled", 32'(LB_readrequest), 32'd0);
      checkOutput("bd1_latency", 32'(BD1_inputready), 32'(prev_rr));
      checkOutput("block_start_latency", 32'(block_start), 32'(prev_rr & prev_row0));
      n_bd1  += int'(BD1_inputready);
      n_bs   += int'(block_start);
      n_rel  += int'(LB_strip_release);
      n_done += int'(frame_done);
    end
    prev_rr   = LB_readrequest;
    prev_row0 = (LB_read_addr[2:0] == 3'd0);
  end

  // Runs one frame. mode: 0 plain, 1 random stall/ready, 2 five-cycle stall
  // at {1,3}, 3 ten-cycle strip_ready gap after first release, 4 start
  // pulse with different cfg during READ
  task automatic runFrame(input int w, input int h, input int mode);
    int cyc, first_rd, rel_cyc, stall_left, gap_left, gap_reads;
    bit stalled_once, gap_done, gap_active, pulsed, done_seen;
    buildModel(w, h);
    n_reads = 0; n_bd1 = 0; n_bs = 0; n_rel = 0; n_done = 0;
    cyc = 0; first_rd = -1; rel_cyc = -1; stall_left = 0; gap_left = 0;
    gap_reads = 0; stalled_once = 0; gap_done = 0; gap_active = 0;
    pulsed = 0; done_seen = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    cfg_width_blk = BLK_W'(w); cfg_height_blk = BLK_W'(h); start = 1'b1;
    applyStimulus(1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_width_blk = BLK_W'($urandom); cfg_height_blk = BLK_W'($urandom);
    while (!done_seen && cyc < 4000) begin
      case (mode)
        1: applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        2: begin
          if (!stalled_once && LB_read_addr == {8'd1, 3'd3}) begin
            stalled_once = 1; stall_left = 5;
          end
          ds_stall = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        3: begin
          if (!gap_done && LB_strip_release) begin
            gap_done = 1; gap_active = 1; gap_left = 10; gap_reads = n_reads;
          end
          if (gap_active && gap_left == 0) begin
            gap_active = 0;
            checkOutput("reads_in_gap", 32'(n_reads - gap_reads), 32'd0);
            checkOutput("busy_in_gap", 32'(busy), 32'd1);
          end
          LB_strip_ready = (gap_left == 0);
          if (gap_left > 0) gap_left--;
        end
        4: begin
          if (!pulsed && n_reads == 3) begin
            pulsed = 1; start = 1'b1; cfg_width_blk = 8'd5; cfg_height_blk = 8'd3;
          end else start = 1'b0;
        end
        default: ;
      endcase
      @(negedge clk);
      if (LB_readrequest && first_rd < 0) first_rd = cyc;
      if (LB_strip_release && rel_cyc < 0) rel_cyc = cyc;
      if (frame_done) done_seen = 1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    applyStimulus(1'b1, 1'b0);
    mon_en = 1'b0;
    checkOutput("frame_timeout", 32'(done_seen), 32'd1);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("model_reads_left", 32'(exp_q.size()), 32'd0);
    checkOutput("read_count", 32'(n_reads), 32'(8 * (w + 1) * (h + 1)));
    checkOutput("bd1_count", 32'(n_bd1), 32'(8 * (w + 1) * (h + 1)));
    checkOutput("block_start_count", 32'(n_bs), 32'((w + 1) * (h + 1)));
    checkOutput("release_count", 32'(n_rel), 32'(h + 1));
    checkOutput("frame_done_count", 32'(n_done), 32'd1);
    if (mode == 2) begin
      checkOutput("stall_read_span", 32'(rel_cyc - first_rd), 32'(8 * (w + 1) + 5));
`ifdef IC_BD_SEQ_STALLCNT_EN
      checkOutput("stall_count", 32'(stall_count), 32'd5);
`endif
    end
    if (mode == 3) checkOutput("gap_exercised", 32'(gap_done), 32'd1);
  endtask

  initial begin
    int waited;
    // Cycle-exact expectations for a 1x1-block frame, sampled after each edge
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) tbl[i] = mk(1, i - 1, i >= 2, i == 2, 0, 0, 1);
    tbl[9]  = mk(0, 0, 1, 0, 1, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0);

    reset_n = 1'b0; start = 1'b0; cfg_width_blk = '0; cfg_height_blk = '0;
    applyStimulus(1'b0, 1'b0);
    #2;
    checkOutput("reset_outputs",
                32'({LB_readrequest, LB_read_addr, LB_strip_release, BD1_inputready,
                     block_start, frame_done, busy}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Table-driven single-block frame
    @(posedge clk); #1;
    cfg_width_blk = 8'd0; cfg_height_blk = 8'd0; start = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      applyStimulus(tbl[i].ready, tbl[i].stall);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i),
                  32'({LB_readrequest, LB_read_addr, BD1_inputready, block_start,
                       LB_strip_release, frame_done, busy}),
                  32'({tbl[i].rr, tbl[i].addr, tbl[i].bd1, tbl[i].bs,
                       tbl[i].rel, tbl[i].done, tbl[i].bsy}));
    end

    runFrame(2, 1, 0);
    runFrame(1, 0, 2);
    runFrame(0, 1, 3);
    runFrame(2, 0, 4);
    for (int k = 0; k < 6; k++)
      runFrame($urandom_range(0, 3), $urandom_range(0, 2), 1);

    // Reset in the middle of a strip
    buildModel(1, 1);
    n_reads = 0; n_rel = 0; n_done = 0; n_bd1 = 0; n_bs = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    cfg_width_blk = 8'd1; cfg_height_blk = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (n_reads < 5 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("reset_test_reads", 32'(n_reads >= 5), 32'd1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midframe_reset_outputs",
                32'({LB_readrequest, LB_read_addr, LB_strip_release, BD1_inputready,
                     block_start, frame_done, busy}), 32'd0);
    @(negedge clk);
    checkOutput("reset_no_pulses", 32'({LB_strip_release, frame_done, busy}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 32'({LB_readrequest, LB_strip_release, frame_done, busy}),
                  32'd0);
    end
    runFrame(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ic_bd_block_sequencer.md
Name: ic_bd_block_sequencer

Overview:
- Front-end scheduler of the 2D binDCT processor.
- Walks a frame in 8x8-block order out of a ping-pong 8-line strip buffer: issues line-buffer read addresses, marks valid rows into the row-DCT stage (BD1), and releases each strip when consumed.
- Honours a downstream stall from the transpose-memory control path; reports block, strip and frame boundaries.

Parameters:
- BLK_W, 8, width of block-column and strip counters (max 2^BLK_W blocks per axis).
- ADDR_W, BLK_W+3, line-buffer word address width: {blk_col, row[2:0]}.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE.
- cfg_width_blk  in  BLK_W  blocks per strip minus 1; sampled on accepted start.
- cfg_height_blk  in  BLK_W  strips per frame minus 1; sampled on accepted start.
- LB_strip_ready  in  1  level; current strip fully written into the line buffer.
- ds_stall  in  1  level; downstream cannot accept rows (transpose memory full).
- LB_readrequest  out  1  read strobe to the line buffer (one 8-pixel row word).
- LB_read_addr  out  ADDR_W  {blk_col, row}.
- LB_strip_release  out  1  one-cycle pulse; strip buffer may be refilled.
- BD1_inputready  out  1  row data valid at BD1 input.
- block_start  out  1  pulse coincident with BD1_inputready for row 0 of each block.
- frame_done  out  1  one-cycle pulse after the last strip is released.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low): FSM=IDLE, all counters 0, all outputs 0, latched cfg 0.
- States: IDLE, WAIT_STRIP, READ, RELEASE, DONE.
- IDLE -> WAIT_STRIP on start. Latch cfg; clear row, blk_col, strip.
- WAIT_STRIP -> READ when LB_strip_ready=1.
- READ:
  - LB_readrequest = (state==READ) && ~ds_stall. This is the only combinational output.
  - LB_read_addr = {blk_col, row}, registered counters.
  - On each issued read, row increments. At row==7, row wraps to 0 and blk_col increments.
  - On a read with row==7 && blk_col==cfg_width_blk, go to RELEASE and clear blk_col.
  - With ds_stall=1: no read, counters hold, state holds. Stall may last indefinitely.
- RELEASE:
  - LB_strip_release=1 for exactly one cycle.
  - If strip==cfg_height_blk, go to DONE. Otherwise strip++ and go to WAIT_STRIP.
  - LB_strip_ready is resampled only in WAIT_STRIP, never in RELEASE.
- DONE: frame_done=1 for one cycle, then IDLE. busy drops in IDLE.
- Latency:
  - Line-buffer read latency is 1 cycle.
  - BD1_inputready = LB_readrequest delayed 1 cycle (registered).
  - block_start = (LB_readrequest && row==0) delayed 1 cycle.
- Throughput: with no stall, one row per cycle, 8 cycles per block. No bubble between blocks within a strip.
- Simultaneous events:
  - start while busy: ignored.
  - ds_stall rising on the cycle of the final row: that read is blocked, and RELEASE waits until it is issued.
- Width rules: counters wrap modulo 2^BLK_W. cfg values equal to 0 mean 1 block / 1 strip.
- Reset mid-frame: immediate return to IDLE. Outputs clear asynchronously. No release or done pulse is emitted.

Optional Feature:
- Macro IC_BD_SEQ_STALLCNT_EN.
- Defined: adds output stall_count [15:0].
  - Counts cycles in READ with ds_stall=1.
  - Saturates at 16'hFFFF.
  - Cleared on accepted start.
  - Holds its value after frame_done.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/include ic_bd_pkg: FSM state encodings (IDLE=0, WAIT_STRIP=1, READ=2, RELEASE=3, DONE=4, 3-bit) and the constant BLOCK_ROWS=8.
- One natural sub-module, ic_bd_block_addr_gen: row/blk_col counters, wrap and last-row detection, address output.
- The FSM and output registers live in the top module.

Test Plan:
- Reset, then start with width=0, height=0, strip_ready=1, no stall -> reads at addr 0..7 in 8 consecutive cycles. BD1_inputready high for 8 cycles starting 1 cycle later. block_start once. One release pulse, then frame_done.
- width=2, height=1, strip_ready always 1 -> 24 reads per strip, with addr sequence {0,r},{1,r},{2,r}. Block_start count is 6, release count is 2, frame_done count is 1, busy deasserts after frame_done.
- ds_stall asserted for 5 cycles at row 3 of block 1 -> exactly 5 missing read cycles, and row 3 is reissued with an unchanged address. With macro defined, stall_count = 5.
- strip_ready held low 10 cycles after the first release -> FSM holds in WAIT_STRIP with no reads. Resumes at {0,0} when strip_ready rises.
- start pulsed during READ -> ignored; counters and cfg unchanged.
- reset_n pulsed low mid-strip -> all outputs 0 within the reset cycle, with no release or frame_done pulse. A fresh start restarts at addr 0.
